uart_rx_fifo: RTL and testbench

Synthesizable UART receiver that deserialises 8-bit frames from a serial line and buffers them in a small FIFO with a valid/ready read interface. It sits on the DUT side directly downstream of the simulation UART model's tx output, and consumes the 8N1 (optionally 8E1/8O1) symbols that model produces. It also reports frame, parity and overflow errors as single-cycle pulses.

---
 rtl/uart_rx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1 / 8E1 / 8O1) feeding a first-word-fall-through receive FIFO.
// Byte visible one cycle after the stop-bit sample; a full FIFO drops new bytes and pulses overflow_o.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rx_i,
  output logic [7:0]                      rdata_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o,
  output logic                            overflow_o
);

  localparam int CPS   = CLK_FREQ / BAUD;
  localparam int CYC_W = $clog2(CPS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CYC_W-1:0] HALF_M1 = CYC_W'(CPS / 2 - 1);
  localparam logic [CYC_W-1:0] FULL_M1 = CYC_W'(CPS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  if (CPS < 4) begin : g_cps_chk
    $error("uart_rx_fifo: CLK_FREQ/BAUD must be >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_bad_q, par_bad_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic               stop_smp, byte_ok, full, push, pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cyc_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    case (state_q)
      S_IDLE: begin
        cyc_cnt_d = '0;
        if (!rx_s_q) begin
          state_d   = S_START;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (cyc_cnt_q == HALF_M1) begin
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cyc_cnt_q == FULL_M1) begin
          cyc_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cyc_cnt_q == FULL_M1) begin
          cyc_cnt_d = '0;
          par_bad_d = ((^shift_q) ^ rx_s_q) != 1'(PARITY_ODD);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cyc_cnt_q == FULL_M1) begin
          cyc_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cyc_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stop-bit outcome: frame error beats parity error beats overflow beats push.
  always_comb begin
    stop_smp     = (state_q == S_STOP) && (cyc_cnt_q == FULL_M1);
    pop          = (count_q != '0) && rready_i;
    full         = (count_q == LVL_FULL);
    frame_err_d  = stop_smp && !rx_s_q;
    parity_err_d = stop_smp && rx_s_q && par_bad_q;
    byte_ok      = stop_smp && rx_s_q && !par_bad_q;
    overflow_d   = byte_ok && full && !pop;
    push         = byte_ok && (!full || pop);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign rvalid_o     = (count_q != '0);
  assign fifo_level_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one 8N1 instance and one 8E1 instance at 16 clocks per symbol.
module tb_uart_rx_fifo;
  localparam int CPS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, rready0, rready1;
  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1;
  logic [3:0] level0, level1;
  logic       fe0_w, pe0_w, ov0_w, fe1_w, pe1_w, ov1_w;

  int n_checks = 0;
  int n_errors = 0;
  int fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0), .rdata_o(rdata0), .rvalid_o(rvalid0),
    .rready_i(rready0), .fifo_level_o(level0), .frame_err_o(fe0_w),
    .parity_err_o(pe0_w), .overflow_o(ov0_w)
  );

  uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1), .rdata_o(rdata1), .rvalid_o(rvalid1),
    .rready_i(rready1), .fifo_level_o(level1), .frame_err_o(fe1_w),
    .parity_err_o(pe1_w), .overflow_o(ov1_w)
  );

  // Cumulative error-pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    fe0 += int'(fe0_w); pe0 += int'(pe0_w); ov0 += int'(ov0_w);
    fe1 += int'(fe1_w); pe1 += int'(pe1_w); ov1 += int'(ov1_w);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the symbol for CPS cycles and returns on a negedge.
  task automatic drive_sym(input bit sel, input bit v);
    if (sel) rx1 = v; else rx0 = v;
    repeat (CPS) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input bit use_par,
                            input bit par_bit, input bit stop_bit);
    drive_sym(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_sym(sel, b[i]);
    if (use_par) drive_sym(sel, par_bit);
    drive_sym(sel, stop_bit);
  endtask

  task automatic pop(input bit sel);
    if (sel) rready1 = 1'b1; else rready0 = 1'b1;
    @(negedge clk);
    if (sel) rready1 = 1'b0; else rready0 = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rready0 = 1'b0; rready1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_rvalid", rvalid0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_level", level0, 0);
    chk("rst_pulses", {fe0_w, pe0_w, ov0_w, fe1_w, pe1_w, ov1_w}, 0);
    chk("rst_par_rvalid", rvalid1, 0);

    // Single 8N1 byte and its latency from the start-bit edge.
    lat = 0; seen = 0;
    fork
      send_frame(0, 8'hA5, 0, 0, 1);
      begin
        while (!seen && lat < 300) begin
          @(negedge clk);
          lat++;
          if (rvalid0) seen = 1;
        end
      end
    join
    chk("t1_seen", seen, 1);
    chk("t1_latency_154_156", (lat >= 154 && lat <= 156), 1);
    chk("t1_rdata", rdata0, 8'hA5);
    chk("t1_level", level0, 1);
    chk("t1_no_err", fe0 + pe0 + ov0, 0);
    pop(0);
    chk("t1_level_after_pop", level0, 0);

    // Nine back-to-back frames into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) send_frame(0, 8'(i), 0, 0, 1);
    chk("t2_level_full", level0, 8);
    chk("t2_overflow_cnt", ov0, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_pop%0d", i), rdata0, 32'(i));
      pop(0);
    end
    chk("t2_empty", rvalid0, 0);

    // Low stop bit followed by a long break.
    send_frame(0, 8'h3C, 0, 0, 0);
    repeat (40 * CPS) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPS) @(negedge clk);
    chk("t3_frame_err_cnt", fe0, 1);
    chk("t3_no_push", level0, 0);
    send_frame(0, 8'h55, 0, 0, 1);
    chk("t3_next_rvalid", rvalid0, 1);
    chk("t3_next_rdata", rdata0, 8'h55);
    pop(0);

    // Even parity: 0x01 needs parity bit 1.
    send_frame(1, 8'h01, 1, 1, 1);
    chk("t4_good_level", level1, 1);
    chk("t4_good_rdata", rdata1, 8'h01);
    chk("t4_good_no_perr", pe1, 0);
    send_frame(1, 8'h01, 1, 0, 1);
    chk("t4_parity_err_cnt", pe1, 1);
    chk("t4_bad_no_push", level1, 1);
    chk("t4_no_frame_err", fe1, 0);

    // Short low glitch while idle.
    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * CPS) @(negedge clk);
    chk("t5_no_push", level0, 0);
    chk("t5_no_new_err", {fe0[7:0], pe0[7:0], ov0[7:0]}, {8'd1, 8'd0, 8'd1});
    send_frame(0, 8'h96, 0, 0, 1);
    chk("t5_after_glitch_rdata", rdata0, 8'h96);
    chk("t5_after_glitch_level", level0, 1);
    pop(0);

    // Push coinciding with pop on a full FIFO.
    for (int i = 0; i < 8; i++) send_frame(0, 8'h10 + 8'(i), 0, 0, 1);
    chk("t6_level_full", level0, 8);
    fork
      send_frame(0, 8'h18, 0, 0, 1);
      begin
        repeat (154) @(negedge clk);
        chk("t6_head_before", rdata0, 8'h10);
        rready0 = 1'b1;
        @(negedge clk);
        rready0 = 1'b0;
      end
    join
    chk("t6_level_stays_full", level0, 8);
    chk("t6_no_overflow", ov0, 1);
    chk("t6_head_after", rdata0, 8'h11);

    // Reset in the middle of a frame with a full FIFO.
    fork
      send_frame(0, 8'hFF, 0, 0, 1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    chk("t6_rst_level", level0, 0);
    chk("t6_rst_rvalid", rvalid0, 0);
    chk("t6_rst_par_level", level1, 0);
    send_frame(0, 8'h7E, 0, 0, 1);
    chk("t6_post_rst_rdata", rdata0, 8'h7E);
    chk("t6_post_rst_level", level0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
